instr_prefetch_queue: RTL

Instruction prefetch unit sitting directly upstream of the pipelined CPU's IF/ID register. It replaces the zero-latency combinational instruction memory lookup with a handshaked fetch port that tolerates variable memory latency. Fetched words are buffered in a small FIFO and handed to IF/ID together with their PC+4. A taken-branch redirect flushes the queue and discards any in-flight fetch.

---
 rtl/instr_prefetch_queue_if.sv | 29 ++
 rtl/instr_prefetch_queue.sv | 133 +++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue_if.sv
// rtl/instr_prefetch_queue_if.sv - fetch port, redirect and IF/ID handoff signals of the prefetch queue
// master: the prefetch unit itself; slave: memory, branch unit and IF/ID stage around it.
interface instr_prefetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic          out_valid;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc_4;
  logic          out_ready;
  logic [CW-1:0] count;

  modport master (
    input  redirect_valid, redirect_pc, mem_ack, mem_rdata, out_ready,
    output mem_req, mem_addr, out_valid, out_instr, out_pc_4, count
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_ack, mem_rdata, out_ready,
    input  mem_req, mem_addr, out_valid, out_instr, out_pc_4, count
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - instruction prefetch FIFO with one-outstanding fetch port and redirect flush
// Words are queued as {pc+4, instr}; a redirect empties the queue and drops any fetch still in flight.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  instr_prefetch_queue_if.master io_pq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    r_state;
  logic [31:0]   r_fetch_pc;
  logic          r_mem_req;
  logic [31:0]   r_mem_addr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_pc_4  [DEPTH];

  logic          w_redirect;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_count_nxt;
  logic          w_space;
  logic [31:0]   w_fetch_pc_inc;

  assign w_redirect     = io_pq.redirect_valid;
  assign w_pop          = (r_count != '0) && io_pq.out_ready && !w_redirect;
  assign w_push         = io_pq.mem_ack && (r_state == S_WAIT) && !w_redirect;
  assign w_count_nxt    = r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
  // Requests only go out when the word they return is guaranteed a slot.
  assign w_space        = w_count_nxt < DEPTH_C;
  assign w_fetch_pc_inc = r_fetch_pc + 32'd4;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_redirect) begin
            r_fetch_pc <= io_pq.redirect_pc;
          end else if (w_space) begin
            r_state    <= S_WAIT;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
          end
        end
        S_WAIT: begin
          if (io_pq.mem_ack) begin
            if (w_redirect) begin
              r_fetch_pc <= io_pq.redirect_pc;
              r_mem_req  <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_fetch_pc <= w_fetch_pc_inc;
              if (w_space) begin
                r_mem_addr <= w_fetch_pc_inc;
              end else begin
                r_mem_req <= 1'b0;
                r_state   <= S_IDLE;
              end
            end
          end else if (w_redirect) begin
            // The old request stays on the bus until memory answers it.
            r_fetch_pc <= io_pq.redirect_pc;
            r_state    <= S_DROP;
          end
        end
        S_DROP: begin
          if (w_redirect) begin
            r_fetch_pc <= io_pq.redirect_pc;
          end
          if (io_pq.mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || w_redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc_4[i]  <= '0;
      end
    end else if (w_push) begin
      r_instr[r_wr_ptr] <= io_pq.mem_rdata;
      r_pc_4[r_wr_ptr]  <= r_mem_addr + 32'd4;
    end
  end

  assign io_pq.mem_req   = r_mem_req;
  assign io_pq.mem_addr  = r_mem_addr;
  assign io_pq.out_valid = (r_count != '0);
  assign io_pq.out_instr = r_instr[r_rd_ptr];
  assign io_pq.out_pc_4  = r_pc_4[r_rd_ptr];
  assign io_pq.count     = r_count;
endmodule
